bcd_scan_counter: RTL and testbench
===================================

// Module: bcd_scan_counter
// PURPOSE
//  Parametrised multi-digit BCD up/down counter with loadable value and terminal-count pulse.
//  Includes a time-multiplexed digit scanner that drives a registered one-hot decimal decode
//  (digits 0..9) of the currently selected digit.
//  Sits between control logic and the display/LED driver; successor to the 4-bit BCD decoder.
// PARAMETERS
//  DIGITS    2  number of BCD digits; legal range 1..8
//  SCAN_DIV  4  clocks per scan slot; must be >= 1
// PORTS
//  clk          in   1          system clock; all state on rising edge
//  rst_n        in   1          asynchronous active-low reset
//  en_i         in   1          count-step enable
//  up_i         in   1          1 = increment, 0 = decrement (sampled when en_i=1)
//  load_i       in   1          synchronous load request
//  load_val_i   in   4*DIGITS   BCD load value; nibble k = digit k, digit 0 is least significant
//  count_o      out  4*DIGITS   current BCD count (registered)
//  tc_o         out  1          terminal-count pulse, 1 cycle wide
//  load_err_o   out  1          invalid-load pulse, 1 cycle wide
//  digit_sel_o  out  DIGITS     one-hot select for the digit being scanned
//  dec_o        out  10         one-hot decode of the selected digit; bit k set when digit == k
// BEHAVIOUR
//  Reset (async, rst_n=0): count_o=0, tc_o=0, load_err_o=0, prescaler=0,
//    digit_sel_o=1 (digit 0), dec_o=10'b0000000001.
//  Priority per cycle: load_i > en_i > hold.
//  Load, all nibbles <=9: count_o<=load_val_i next cycle; tc_o=0; load_err_o=0.
//  Load, any nibble >9: count held; load_err_o=1 for exactly one cycle; no partial load.
//    - A rejected load still blocks en_i for that cycle.
//  Up step: digit 0 +1; a digit at 9 becomes 0 and carries to the next digit (ripple in one cycle).
//  Down step: digit 0 -1; a digit at 0 becomes 9 and borrows from the next digit.
//  Wrap (default build):
//    - all-9s + up -> all-0s; all-0s + down -> all-9s.
//    - tc_o=1 in the same cycle the wrapped value appears on count_o.
//  tc_o and load_err_o are 0 in every other cycle; they are never asserted together.
//  Scan:
//    - Prescaler counts 0..SCAN_DIV-1 continuously, independent of en_i and load_i.
//    - On the prescaler's terminal value, digit_sel_o rotates left (digit DIGITS-1 -> digit 0).
//    - DIGITS=1: digit_sel_o is constant 1.
//  dec_o latency: registered from count_o and the selection index of the previous cycle.
//    - dec_o follows digit_sel_o/count_o by exactly one clock.
//    - Never more than one bit set; never all-zero after reset.
//  Reset mid-operation: all state returns to reset values immediately; no pulse outputs glitch high.
// CONFIGURATION
//  BCD_SAT_EN defined:
//    - Counter saturates; up at all-9s and down at all-0s leave count_o unchanged.
//    - tc_o pulses one cycle for each such blocked step.
//  BCD_SAT_EN undefined: wrap behaviour as above.
//  Load checking, scan and decode are identical in both builds.
// STRUCTURE
//  Shared include bcd_pkg.vh holds:
//    - BCD_MAX = 4'd9, BCD_MIN = 4'd0;
//    - function bcd_is_valid(nibble);
//    - function bcd_to_onehot10(nibble), which returns 0 for nibbles >9.
//  Sub-module bcd_digit (one per digit via generate):
//    - ports clk, rst_n, ld, ld_val[3:0], step, up, cin, q[3:0], cout;
//    - cout = step & cin & (up ? q==9 : q==0); digit 0 has cin=1.
//  Top level holds load validation, the tc/load_err registers, prescaler, scan pointer and dec_o register.
// TESTING (DIGITS=2, SCAN_DIV=4 unless noted)
//  1. rst_n=0 mid-count -> count_o=8'h00, digit_sel_o=2'b01, dec_o=10'h001, tc_o=0, load_err_o=0.
//  2. load 8'h98, then en_i=1 up_i=1 for 2 cycles -> count_o 8'h99 then 8'h00; tc_o=1 only with 8'h00.
//  3. load 8'h00, en_i=1 up_i=0 -> default build: 8'h99, tc_o pulse.
//     BCD_SAT_EN build: stays 8'h00, tc_o pulse.
//  4. load_val_i=8'h3A -> count_o unchanged, load_err_o=1 one cycle.
//     load_i with en_i=1 and load_val_i=8'h25 -> count_o=8'h25 (load wins).
//  5. count 8'h47, free-run scan -> digit_sel_o alternates 01/10 every 4 clocks.
//     dec_o=10'h080 (7) when digit 0 selected, 10'h010 (4) when digit 1 selected, each one clock after digit_sel_o changes.
//  6. DIGITS=3, up from 12'h099 -> 12'h100 in one step (double carry), tc_o=0.

Source files
------------

// File: rtl/bcd_scan_counter_pkg.sv
// Shared BCD constants and helpers for the BCD scan counter.
package bcd_scan_counter_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  // True when the nibble is a legal decimal digit.
  function automatic logic bcd_is_valid(input logic [3:0] nibble);
    return (nibble <= BCD_MAX);
  endfunction

  // One-hot decimal decode; non-BCD nibbles decode to all-zero.
  function automatic logic [9:0] bcd_to_onehot10(input logic [3:0] nibble);
    logic [9:0] onehot;
    onehot = '0;
    if (nibble <= BCD_MAX) begin
      onehot = 10'(1) << nibble;
    end
    return onehot;
  endfunction

endpackage

// File: rtl/bcd_scan_counter_digit.sv
// Single BCD digit cell (module bcd_digit): loadable, up/down with carry/borrow chain.
module bcd_digit
  import bcd_scan_counter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ld,
  input  logic [3:0] ld_val,
  input  logic       step,
  input  logic       up,
  input  logic       cin,
  output logic [3:0] q,
  output logic       cout
);

  logic [3:0] q_d;
  logic [3:0] q_q;

  // Carry/borrow out when this digit rolls over during an enabled step.
  assign cout = step & cin & (up ? (q_q == BCD_MAX) : (q_q == BCD_MIN));
  assign q    = q_q;

  // Next digit value: load wins, otherwise advance only when the lower digits roll over.
  always_comb begin
    q_d = q_q;
    if (ld) begin
      q_d = ld_val;
    end else if (step && cin) begin
      if (up) begin
        q_d = (q_q == BCD_MAX) ? BCD_MIN : q_q + 4'd1;
      end else begin
        q_d = (q_q == BCD_MIN) ? BCD_MAX : q_q - 4'd1;
      end
    end
  end

  // Digit register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= BCD_MIN;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with validated load, terminal-count pulse and a
// time-multiplexed digit scanner driving a registered one-hot decimal decode.
// Optional build macro BCD_SAT_EN: saturate at all-9s / all-0s instead of wrapping.
module bcd_scan_counter
  import bcd_scan_counter_pkg::*;
#(
  parameter int DIGITS   = 2,
  parameter int SCAN_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_i,
  input  logic                  up_i,
  input  logic                  load_i,
  input  logic [4*DIGITS-1:0]   load_val_i,
  output logic [4*DIGITS-1:0]   count_o,
  output logic                  tc_o,
  output logic                  load_err_o,
  output logic [DIGITS-1:0]     digit_sel_o,
  output logic [9:0]            dec_o
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic              load_ok;
  logic              at_limit;
  logic              step;
  logic              ld;
  logic [DIGITS-1:0] cin;
  logic [DIGITS-1:0] cout;

  logic              tc_d,       tc_q;
  logic              load_err_d, load_err_q;
  logic [PW-1:0]     presc_d,    presc_q;
  logic [IW-1:0]     idx_d,      idx_q;
  logic [DIGITS-1:0] sel_d,      sel_q;
  logic [9:0]        dec_d,      dec_q;
  logic [3:0]        sel_nib;

  // Load validation and detection of the all-9s (up) / all-0s (down) boundary.
  always_comb begin
    load_ok  = 1'b1;
    at_limit = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (!bcd_is_valid(load_val_i[4*k +: 4])) load_ok = 1'b0;
      if (count_o[4*k +: 4] != (up_i ? BCD_MAX : BCD_MIN)) at_limit = 1'b0;
    end
  end

  assign ld = load_i & load_ok;
`ifdef BCD_SAT_EN
  assign step = en_i & ~load_i & ~at_limit;
`else
  assign step = en_i & ~load_i;
`endif

  // A rejected load still blocks stepping, so both pulses depend on load_i alone.
  // The top carry term equals the boundary term when wrapping and is 0 when saturating.
  assign tc_d       = (en_i & ~load_i & at_limit) | cout[DIGITS-1];
  assign load_err_d = load_i & ~load_ok;

  assign cin[0] = 1'b1;
  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    if (k > 0) begin : g_chain
      assign cin[k] = cout[k-1];
    end
    bcd_digit u_digit (
      .clk    (clk),
      .rst_n  (rst_n),
      .ld     (ld),
      .ld_val (load_val_i[4*k +: 4]),
      .step   (step),
      .up     (up_i),
      .cin    (cin[k]),
      .q      (count_o[4*k +: 4]),
      .cout   (cout[k])
    );
  end

  // Prescaler and scan pointer; the pointer advances on the prescaler's last count.
  always_comb begin
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_d = '0;
      idx_d   = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
    sel_d = DIGITS'(1) << idx_d;
  end

  // Decode of the digit selected this cycle, registered so dec_o lags selection by one clock.
  always_comb begin
    sel_nib = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IW'(k)) sel_nib = count_o[4*k +: 4];
    end
    dec_d = bcd_to_onehot10(sel_nib);
  end

  // Pulse, scan and decode registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tc_q       <= 1'b0;
      load_err_q <= 1'b0;
      presc_q    <= '0;
      idx_q      <= '0;
      sel_q      <= DIGITS'(1);
      dec_q      <= 10'd1;
    end else begin
      tc_q       <= tc_d;
      load_err_q <= load_err_d;
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      sel_q      <= sel_d;
      dec_q      <= dec_d;
    end
  end

  assign tc_o        = tc_q;
  assign load_err_o  = load_err_q;
  assign digit_sel_o = sel_q;
  assign dec_o       = dec_q;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Directed bench for bcd_scan_counter (DIGITS=2/SCAN_DIV=4 plus a DIGITS=3 instance).
module tb_bcd_scan_counter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_i, up_i, load_i;
  logic [7:0]  load_val_i;
  logic [7:0]  count_o;
  logic        tc_o, load_err_o;
  logic [1:0]  digit_sel_o;
  logic [9:0]  dec_o;

  logic        en3, up3, load3;
  logic [11:0] load_val3;
  logic [11:0] count3;
  logic        tc3, err3;
  logic [2:0]  sel3;
  logic [9:0]  dec3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bcd_scan_counter #(.DIGITS(2), .SCAN_DIV(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .up_i(up_i), .load_i(load_i),
    .load_val_i(load_val_i), .count_o(count_o), .tc_o(tc_o),
    .load_err_o(load_err_o), .digit_sel_o(digit_sel_o), .dec_o(dec_o)
  );

  bcd_scan_counter #(.DIGITS(3), .SCAN_DIV(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .en_i(en3), .up_i(up3), .load_i(load3),
    .load_val_i(load_val3), .count_o(count3), .tc_o(tc3),
    .load_err_o(err3), .digit_sel_o(sel3), .dec_o(dec3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] onehot(input logic [3:0] n);
    logic [9:0] r;
    r = '0;
    if (n <= 4'd9) r[n] = 1'b1;
    return r;
  endfunction

  typedef struct {
    logic       load;
    logic [7:0] val;
    logic       en;
    logic       up;
    logic [7:0] exp_cnt;
    logic       exp_tc;
    logic       exp_err;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [7:0] prev_cnt;
    logic [1:0] m_sel;
    int         m_presc;
    logic [9:0] m_dec;
    logic [3:0] nib;

    // {load, val, en, up, count, tc, err}
    vecs.push_back('{1'b1, 8'h98, 1'b0, 1'b0, 8'h98, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 8'h99, 1'b0, 1'b0});
`ifdef BCD_SAT_EN
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 8'h99, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 8'h99, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 8'h99, 1'b0, 1'b0, 8'h99, 1'b0, 1'b0});
`else
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 8'h99, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 8'h99, 1'b0, 1'b0});
`endif
    vecs.push_back('{1'b1, 8'h3A, 1'b0, 1'b0, 8'h99, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 8'h99, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 8'h25, 1'b1, 1'b1, 8'h25, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 8'h24, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 8'h09, 1'b0, 1'b0, 8'h09, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 8'h10, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 8'h09, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 8'hA0, 1'b1, 1'b1, 8'h09, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 8'h08, 1'b0, 1'b0});

    rst_n = 1'b0; en_i = 0; up_i = 0; load_i = 0; load_val_i = '0;
    en3 = 0; up3 = 0; load3 = 0; load_val3 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", count_o, 8'h00);
    check("rst_sel",   digit_sel_o, 2'b01);
    check("rst_dec",   dec_o, 10'h001);
    check("rst_tc",    tc_o, 1'b0);
    check("rst_err",   load_err_o, 1'b0);
    @(negedge clk) rst_n = 1'b1;

    // Table-driven count/load vectors
    foreach (vecs[i]) begin
      @(negedge clk);
      load_i = vecs[i].load; load_val_i = vecs[i].val;
      en_i = vecs[i].en; up_i = vecs[i].up;
      @(posedge clk); #1;
      check($sformatf("vec%0d_count", i), count_o, vecs[i].exp_cnt);
      check($sformatf("vec%0d_tc", i), tc_o, vecs[i].exp_tc);
      check($sformatf("vec%0d_err", i), load_err_o, vecs[i].exp_err);
    end

    // Async reset mid-operation, just as a wrap would be flagged
    @(negedge clk);
    load_i = 1'b1; load_val_i = 8'h99; en_i = 0;
    @(negedge clk);
    load_i = 1'b0; en_i = 1'b1; up_i = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst_count", count_o, 8'h00);
    check("midrst_tc",    tc_o, 1'b0);
    check("midrst_err",   load_err_o, 1'b0);
    check("midrst_sel",   digit_sel_o, 2'b01);
    check("midrst_dec",   dec_o, 10'h001);
    en_i = 1'b0;

    // Scan: load 47 as reset releases, then watch selection and decode lag
    @(negedge clk);
    load_i = 1'b1; load_val_i = 8'h47;
    rst_n = 1'b1;
    prev_cnt = 8'h00; m_sel = 2'b01; m_presc = 0; m_dec = 10'h001;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      nib     = (m_sel == 2'b01) ? prev_cnt[3:0] : prev_cnt[7:4];
      m_dec   = onehot(nib);
      if (m_presc == 3) begin
        m_presc = 0;
        m_sel   = {m_sel[0], m_sel[1]};
      end else begin
        m_presc++;
      end
      prev_cnt = 8'h47;
      check($sformatf("scan%0d_sel", c), digit_sel_o, m_sel);
      check($sformatf("scan%0d_dec", c), dec_o, m_dec);
      if (c == 0) load_i = 1'b0;
    end
    check("scan_count", count_o, 8'h47);

    // Three digits: double carry 099 -> 100 in one step
    @(negedge clk);
    load3 = 1'b1; load_val3 = 12'h099;
    @(negedge clk);
    load3 = 1'b0; en3 = 1'b1; up3 = 1'b1;
    check("d3_load", count3, 12'h099);
    @(posedge clk); #1;
    check("d3_carry", count3, 12'h100);
    check("d3_tc", tc3, 1'b0);
    @(negedge clk);
    up3 = 1'b0;
    @(posedge clk); #1;
    check("d3_borrow", count3, 12'h099);
    en3 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
